// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and the RAM port-grant encoding for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int FIFO_DW = 8;
  localparam int FIFO_AW = 8;

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_PUSH,
    GRANT_FETCH
  } grant_e;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop streaming handshakes plus the single-port RAM bus, bundled for the FIFO controller.
interface ram_fifo_ctrl_if #(
  parameter int DW = ram_fifo_ctrl_pkg::FIFO_DW,
  parameter int AW = ram_fifo_ctrl_pkg::FIFO_AW
);

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  // The controller side; the RAM and the stream producer/consumer use master.
  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_dout,
    output wr_ready, rd_valid, rd_data, ram_din, ram_addr, ram_en, ram_we
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_dout,
    input  wr_ready, rd_valid, rd_data, ram_din, ram_addr, ram_en, ram_we
  );

endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer that absorbs RAM read data; slot0 is always the head word.
module ram_fifo_obuf
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          capture,
  input  logic [DW-1:0] cap_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    ocount
);

  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;

  // Capture lands at the tail; a simultaneous pop shifts first so the tail moves down one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0  <= '0;
      slot1  <= '0;
      ocount <= 2'd0;
    end else if (flush) begin
      slot0  <= '0;
      slot1  <= '0;
      ocount <= 2'd0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (ocount == 2'd0) slot0 <= cap_data;
          else                slot1 <= cap_data;
          ocount <= ocount + 2'd1;
        end
        2'b01: begin
          slot0  <= slot1;
          ocount <= ocount - 2'd1;
        end
        2'b11: begin
          if (ocount == 2'd2) begin
            slot0 <= slot1;
            slot1 <= cap_data;
          end else begin
            slot0 <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO built on a 256x8 single-port RAM: owns pointers, word counts and port arbitration.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  ram_fifo_ctrl_if.slave  bus,
  output logic [AW+1:0]   level,
  output logic            full,
  output logic            empty
);

  localparam int DEPTH = 2 ** AW;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   mem_count;
  logic          inflight;
  logic [1:0]    ocount;
  logic          fetch_req;
  logic          fetch_win;
  logic          pop;
  grant_e        grant;

  assign full      = (mem_count == (AW+1)'(DEPTH));
  assign fetch_req = (mem_count != '0) && (({1'b0, ocount} + {2'b0, inflight}) < 3'd2);
  assign fetch_win = fetch_req && (ocount == 2'd0) && !inflight;
  assign level     = {1'b0, mem_count} + {{AW{1'b0}}, ocount} + {{(AW+1){1'b0}}, inflight};
  assign empty     = (level == '0);

  assign bus.wr_ready = !full && !clr && !fetch_win;
  assign bus.rd_valid = (ocount != 2'd0);
  assign pop          = bus.rd_valid && bus.rd_ready && !clr;

  // Reset is folded in so the RAM port goes quiet the instant rst_n falls, not at the next edge.
  always_comb begin
    grant = GRANT_IDLE;
    if (rst_n && !clr) begin
      if (fetch_win)                 grant = GRANT_FETCH;
      else if (bus.wr_valid && !full) grant = GRANT_PUSH;
      else if (fetch_req)            grant = GRANT_FETCH;
    end
  end

  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    case (grant)
      GRANT_PUSH: begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = wptr;
        bus.ram_din  = bus.wr_data;
      end
      GRANT_FETCH: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = rptr;
      end
      default: ;
    endcase
  end

  // Push and fetch are mutually exclusive, so mem_count only ever moves by one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= (grant == GRANT_FETCH);
      case (grant)
        GRANT_PUSH: begin
          wptr      <= wptr + 1'b1;
          mem_count <= mem_count + 1'b1;
        end
        GRANT_FETCH: begin
          rptr      <= rptr + 1'b1;
          mem_count <= mem_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  ram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (clr),
    .capture  (inflight),
    .cap_data (bus.ram_dout),
    .pop      (pop),
    .head     (bus.rd_data),
    .ocount   (ocount)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: behavioural RAM, queue reference model, directed and random traffic.
module tb_ram_fifo_ctrl;
  import ram_fifo_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic [FIFO_AW+1:0]   level;
  logic                 full;
  logic                 empty;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] expQ[$];
  logic [7:0] ramMem[256];
  bit         written[256];
  bit         sawTop;
  bit         wrapSeen;

  ram_fifo_ctrl_if bus();

  ram_fifo_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural RAM with one-cycle read latency, plus the push side of the scoreboard.
  always @(posedge clk) begin
    if (!rst_n || clr) begin
      expQ.delete();
      for (int i = 0; i < 256; i++) written[i] = 1'b0;
      sawTop   = 1'b0;
      wrapSeen = 1'b0;
    end else begin
      if (bus.ram_en) begin
        if (bus.ram_we) begin
          ramMem[bus.ram_addr] <= bus.ram_din;
          written[bus.ram_addr] = 1'b1;
          if (bus.ram_addr == 8'hFF) sawTop = 1'b1;
          else if (bus.ram_addr == 8'h00 && sawTop) wrapSeen = 1'b1;
        end else begin
          checkOutput("read_of_written_addr", {31'b0, written[bus.ram_addr]}, 32'd1);
          bus.ram_dout <= ramMem[bus.ram_addr];
        end
      end
      if (bus.wr_valid && bus.wr_ready) expQ.push_back(bus.wr_data);
    end
  end

  // Monitor: level/empty track the model's word count; every pop must match the model head.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("level", 32'(level), 32'(expQ.size()));
      checkOutput("empty", {31'b0, empty}, {31'b0, expQ.size() == 0});
      if (bus.rd_valid) begin
        checkOutput("valid_has_data", {31'b0, expQ.size() != 0}, 32'd1);
        if (bus.rd_ready && !clr && expQ.size() != 0)
          checkOutput("rd_data", 32'(bus.rd_data), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit rr, input bit c);
    @(posedge clk);
    #1;
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.rd_ready = rr;
    clr          = c;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_wr_ready"}, {31'b0, bus.wr_ready}, 32'd1);
    checkOutput({tag, "_rd_valid"}, {31'b0, bus.rd_valid}, 32'd0);
    checkOutput({tag, "_rd_data"},  32'(bus.rd_data), 32'd0);
    checkOutput({tag, "_level"},    32'(level), 32'd0);
    checkOutput({tag, "_full"},     {31'b0, full}, 32'd0);
    checkOutput({tag, "_empty"},    {31'b0, empty}, 32'd1);
    checkOutput({tag, "_ram_en"},   {31'b0, bus.ram_en}, 32'd0);
    checkOutput({tag, "_ram_we"},   {31'b0, bus.ram_we}, 32'd0);
    checkOutput({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    checkOutput({tag, "_ram_din"},  32'(bus.ram_din), 32'd0);
  endtask

  task automatic drainAll(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      done = empty;
    end
    checkOutput({tag, "_drain_done"}, {31'b0, done}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;
    clr          = 1'b0;
    rst_n        = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkResetValues("por");

    // Single word: fetch in cycle 1, head visible in cycle 3
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_push_we", {31'b0, bus.ram_we}, 32'd1);
    checkOutput("single_push_din", 32'(bus.ram_din), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_fetch_en", {31'b0, bus.ram_en}, 32'd1);
    checkOutput("single_fetch_we", {31'b0, bus.ram_we}, 32'd0);
    checkOutput("single_fetch_addr", 32'(bus.ram_addr), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_c2_valid", {31'b0, bus.rd_valid}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_c3_valid", {31'b0, bus.rd_valid}, 32'd1);
    checkOutput("single_c3_data", 32'(bus.rd_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("single_level_after_pop", 32'(level), 32'd0);

    // Collision: fetch beats a waiting push when the output buffer is empty
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("coll_c0_ready", {31'b0, bus.wr_ready}, 32'd1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("coll_c1_ready", {31'b0, bus.wr_ready}, 32'd0);
    checkOutput("coll_c1_fetch", {30'b0, bus.ram_en, bus.ram_we}, 32'd2);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("coll_c2_ready", {31'b0, bus.wr_ready}, 32'd1);
    checkOutput("coll_c2_push_addr", 32'(bus.ram_addr), 32'd2);
    drainAll("coll");

    // Flush while a fetch is in flight and the head buffer holds a word
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_pre_fetch", {30'b0, bus.ram_en, bus.ram_we}, 32'd2);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_pre_level", 32'(level), 32'd3);
    checkOutput("flush_no_ram_access", {31'b0, bus.ram_en}, 32'd0);
    checkOutput("flush_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush_stale_not_captured", {31'b0, bus.rd_valid}, 32'd0);
    drainAll("flush");

    // Fill to DEPTH+2 with no pops, then confirm pushes are refused
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idx = 0;
    for (int cyc = 0; cyc < 3000 && idx < 258; cyc++) begin
      applyStimulus(1'b1, 8'(idx), 1'b0, 1'b0);
      @(negedge clk);
      if (bus.wr_ready) idx++;
    end
    checkOutput("fill_accepted", 32'(idx), 32'd258);
    repeat (4) begin
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("fill_full_refuses", {31'b0, bus.wr_ready}, 32'd0);
    end
    checkOutput("fill_level", 32'(level), 32'd258);
    checkOutput("fill_full", {31'b0, full}, 32'd1);
    drainAll("fill");

    // Random stream of 600 incrementing bytes across pointer wrap
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idx = 0;
    for (int cyc = 0; cyc < 20000 && idx < 600; cyc++) begin
      applyStimulus(($urandom % 4) != 0, 8'(idx), ($urandom % 2) != 0, 1'b0);
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) idx++;
    end
    checkOutput("stream_accepted", 32'(idx), 32'd600);
    drainAll("stream");
    checkOutput("stream_addr_wrap", {31'b0, wrapSeen}, 32'd1);

    // Asynchronous reset mid-stream with a push request still asserted
    for (int cyc = 0; cyc < 20; cyc++) begin
      applyStimulus(1'b1, 8'(cyc + 8'h80), ($urandom % 2) != 0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_rst");
    bus.wr_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    drainAll("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
